uart_frame_collector: RTL
=========================

// Module: uart_frame_collector
//
// PURPOSE
//   Consumes the byte strobe from the UART receiver and rebuilds framed
//   16-bit samples for the FFT core. A frame is one SYNC_BYTE header followed
//   by FRAME_LEN samples, each sent low byte first. Samples are buffered in a
//   frame RAM, then drained to the FFT input over a valid/ready stream with a
//   last marker.
//
// PARAMETERS
//   FRAME_LEN  64     samples per frame; power of two, >= 2
//   SYNC_BYTE  8'hA5  header byte that opens a frame
//   ADDR_W     (local) $clog2(FRAME_LEN); not overridable
//
// PORTS
//   i_clk           in   1   single clock; all logic is on its rising edge
//   i_rst           in   1   reset, synchronous, active-high
//   i_rx_flag       in   1   one-cycle strobe: i_rx_byte is valid
//   i_rx_byte       in   8   received byte
//   o_sample        out  16  sample to the FFT, {hi, lo}
//   o_sample_valid  out  1   o_sample is valid
//   i_sample_ready  in   1   FFT accepts o_sample when valid && ready
//   o_sample_last   out  1   qualifies the final sample (index FRAME_LEN-1)
//   o_busy          out  1   high in s_LO, s_HI and s_DRAIN
//   o_overrun       out  1   sticky: a byte arrived during s_DRAIN and was dropped
//
// BEHAVIOUR
//   - Reset: all outputs 0; state s_SYNC; wr_idx = rd_idx = 0; lo_reg = 0.
//     A reset mid-frame discards the partial frame and any undrained data.
//   - s_SYNC: on a flag with byte == SYNC_BYTE -> s_LO. Other bytes are ignored.
//   - s_LO: on a flag, latch lo_reg <= byte -> s_HI.
//   - s_HI: on a flag, write {byte, lo_reg} to ram[wr_idx].
//       - If wr_idx == FRAME_LEN-1: wr_idx <= 0, rd_idx <= 0, go to s_DRAIN.
//       - Otherwise: wr_idx++, go to s_LO.
//   - Inside a frame there is no re-sync: a SYNC_BYTE value is treated as data.
//   - Cycles with no flag hold the state; there is no timeout.
//   - s_DRAIN uses RAM with a 1-cycle synchronous read.
//       - o_sample_valid first rises 2 cycles after the flag that wrote the
//         last sample.
//       - While valid && !ready, o_sample, o_sample_valid and o_sample_last are
//         held stable.
//       - On a handshake, valid drops for exactly 1 cycle while ram[rd_idx+1] is
//         read, then rises again. Peak rate is one sample per 2 cycles.
//       - o_sample_last = valid && (rd_idx == FRAME_LEN-1).
//       - The handshake on the last sample clears valid and last, and the block
//         returns to s_SYNC on the next cycle.
//   - A flag seen in s_DRAIN drops the byte and sets o_overrun, which stays
//     high until i_rst. The buffered frame is not affected.
//   - i_sample_ready is ignored whenever o_sample_valid is 0.
//   - Index counters are ADDR_W bits wide and wrap naturally. No arithmetic is
//     applied to samples; they pass through bit-exact.
//
// STRUCTURE
//   - Shared package fft_h_pkg holds:
//       - state localparams: s_SYNC = 2'd0, s_LO = 2'd1, s_HI = 2'd2,
//         s_DRAIN = 2'd3;
//       - SAMPLE_W = 16;
//       - the default SYNC_BYTE.
//   - One sub-module, frame_ram: simple dual-port, depth FRAME_LEN, width
//     SAMPLE_W, one write port, registered read port, no reset on contents.
//   - The FSM, the counters and the output register stay in this module.
//
// TESTING  (FRAME_LEN=4 unless noted)
//   1. Assert i_rst for 2 cycles with random inputs -> every output is 0 and
//      the first post-reset A5 is accepted.
//   2. Send 11, A5, 34 12, 78 56, BC 9A, F0 DE -> samples 1234, 5678, 9ABC,
//      DEF0 appear, last only on DEF0; 11 is ignored.
//   3. Hold ready low for 5 cycles on the 2nd sample -> valid=1 and o_sample
//      stays 5678 throughout; 1-cycle bubble after each handshake.
//   4. Send a byte 00 mid-drain -> o_overrun=1 (sticky); the drained frame is
//      unchanged; the next A5 frame is collected correctly.
//   5. Send A5, 34, 12, 78, then i_rst -> o_busy=0, no output; a fresh frame
//      then yields 1234 first.
//   6. Send A5 then A5 A5 x4 -> four samples of A5A5 (no re-sync).
//   7. FRAME_LEN=64 with an incrementing pattern and random ready -> 64
//      in-order samples, last on index 63, wr_idx wraps to 0.

Source files
------------

// File: rtl/fft_h_pkg.sv
// Shared definitions for the UART frame collector: FSM state encodings,
// sample width and the default frame header byte.
package fft_h_pkg;

   localparam logic [1:0] s_SYNC  = 2'd0;
   localparam logic [1:0] s_LO    = 2'd1;
   localparam logic [1:0] s_HI    = 2'd2;
   localparam logic [1:0] s_DRAIN = 2'd3;

   localparam int SAMPLE_W = 16;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_frame_collector_if.sv
// Byte-in / sample-out signal bundle of the frame collector.
// master = byte source and FFT sink side, slave = the collector.
interface uart_frame_collector_if;
   import fft_h_pkg::*;

   logic                i_rx_flag;
   logic [7:0]          i_rx_byte;
   logic [SAMPLE_W-1:0] o_sample;
   logic                o_sample_valid;
   logic                i_sample_ready;
   logic                o_sample_last;
   logic                o_busy;
   logic                o_overrun;

   modport master (
      output i_rx_flag, i_rx_byte, i_sample_ready,
      input  o_sample, o_sample_valid, o_sample_last, o_busy, o_overrun
   );

   modport slave (
      input  i_rx_flag, i_rx_byte, i_sample_ready,
      output o_sample, o_sample_valid, o_sample_last, o_busy, o_overrun
   );

endinterface

// File: rtl/frame_ram.sv
// Simple dual-port frame buffer: one write port, registered read port.
// Contents are not reset.
module frame_ram
   import fft_h_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic                i_clk,
   input  logic                we,
   input  logic [ADDR_W-1:0]   waddr,
   input  logic [SAMPLE_W-1:0] wdata,
   input  logic [ADDR_W-1:0]   raddr,
   output logic [SAMPLE_W-1:0] rdata
);

   logic [SAMPLE_W-1:0] mem [DEPTH];

   // Write port: store a completed sample.
   always_ff @(posedge i_clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read port: one-cycle synchronous read, every cycle.
   always_ff @(posedge i_clk) begin
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/uart_frame_collector.sv
// Rebuilds 16-bit samples (low byte first) from a UART byte strobe after a
// sync header, buffers one frame and drains it over valid/ready with last.
module uart_frame_collector
   import fft_h_pkg::*;
#(
   parameter int         FRAME_LEN = 64,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   uart_frame_collector_if.slave  bus
);

   localparam int ADDR_W = $clog2(FRAME_LEN);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

   logic [1:0]          state;
   logic [1:0]          state_next;
   logic [ADDR_W-1:0]   wr_idx;
   logic [ADDR_W-1:0]   rd_idx;
   logic [ADDR_W-1:0]   rd_addr;
   logic [7:0]          lo_reg;
   logic                fetch;      // a RAM read was issued last cycle
   logic                valid;
   logic                last;
   logic [SAMPLE_W-1:0] sample;
   logic                overrun;
   logic                busy;
   logic                ram_we;
   logic [SAMPLE_W-1:0] ram_rdata;
   logic                hs;

   assign hs = valid && bus.i_sample_ready;

   frame_ram #(
      .DEPTH  (FRAME_LEN),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .i_clk (i_clk),
      .we    (ram_we),
      .waddr (wr_idx),
      .wdata ({bus.i_rx_byte, lo_reg}),
      .raddr (rd_addr),
      .rdata (ram_rdata)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= s_SYNC;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: header hunt, byte pairing, frame drain.
   always_comb begin
      state_next = state;
      case (state)
         s_SYNC: begin
            if (bus.i_rx_flag && (bus.i_rx_byte == SYNC_BYTE)) begin
               state_next = s_LO;
            end else begin
               state_next = s_SYNC;
            end
         end
         s_LO: begin
            if (bus.i_rx_flag) begin
               state_next = s_HI;
            end else begin
               state_next = s_LO;
            end
         end
         s_HI: begin
            if (bus.i_rx_flag) begin
               state_next = (wr_idx == LAST_IDX) ? s_DRAIN : s_LO;
            end else begin
               state_next = s_HI;
            end
         end
         s_DRAIN: begin
            if (hs && (rd_idx == LAST_IDX)) begin
               state_next = s_SYNC;
            end else begin
               state_next = s_DRAIN;
            end
         end
         default: state_next = s_SYNC;
      endcase
   end

   // State-decoded controls: busy, RAM write, read address look-ahead.
   always_comb begin
      busy    = 1'b0;
      ram_we  = 1'b0;
      rd_addr = rd_idx;
      case (state)
         s_SYNC:  busy = 1'b0;
         s_LO:    busy = 1'b1;
         s_HI: begin
            busy   = 1'b1;
            ram_we = bus.i_rx_flag;
         end
         s_DRAIN: begin
            busy = 1'b1;
            // On a handshake, fetch the following sample in the same edge.
            if (hs) begin
               rd_addr = rd_idx + ADDR_W'(1);
            end else begin
               rd_addr = rd_idx;
            end
         end
         default: busy = 1'b0;
      endcase
   end

   // Datapath: low-byte latch, indices, output register, sticky overrun.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_idx  <= '0;
         rd_idx  <= '0;
         lo_reg  <= 8'h00;
         fetch   <= 1'b0;
         valid   <= 1'b0;
         last    <= 1'b0;
         sample  <= '0;
         overrun <= 1'b0;
      end else begin
         case (state)
            s_LO: begin
               if (bus.i_rx_flag) begin
                  lo_reg <= bus.i_rx_byte;
               end
            end
            s_HI: begin
               if (bus.i_rx_flag) begin
                  if (wr_idx == LAST_IDX) begin
                     wr_idx <= '0;
                     rd_idx <= '0;
                     fetch  <= 1'b0;
                  end else begin
                     wr_idx <= wr_idx + ADDR_W'(1);
                  end
               end
            end
            s_DRAIN: begin
               if (bus.i_rx_flag) begin
                  overrun <= 1'b1;
               end
               if (hs) begin
                  valid  <= 1'b0;
                  last   <= 1'b0;
                  rd_idx <= rd_idx + ADDR_W'(1);
                  fetch  <= (rd_idx != LAST_IDX);
               end else if (fetch) begin
                  valid  <= 1'b1;
                  sample <= ram_rdata;
                  last   <= (rd_idx == LAST_IDX);
                  fetch  <= 1'b0;
               end else if (!valid) begin
                  // First read of the frame after the final write.
                  fetch <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_sample       = sample;
   assign bus.o_sample_valid = valid;
   assign bus.o_sample_last  = last;
   assign bus.o_busy         = busy;
   assign bus.o_overrun      = overrun;

endmodule
